// File: rtl/dbg_imem_reader.sv
// Debug readback of instruction memory: streams req_count words from req_start_addr
// through a 2-entry output FIFO, issuing at most one read per cycle under a credit limit.
module dbg_imem_reader #(
    parameter int XLEN               = 64,
    parameter int INSTRUCTION_LENGTH = XLEN/2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [XLEN-1:0]               req_start_addr,
    input  logic [15:0]                   req_count,
    output logic                          mem_rd_en,
    output logic [XLEN-1:0]               mem_rd_addr,
    input  logic [INSTRUCTION_LENGTH-1:0] mem_rd_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [XLEN-1:0]               out_addr,
    output logic [INSTRUCTION_LENGTH-1:0] out_instr,
    output logic                          out_last,
    output logic                          busy,
    output logic                          done,
    output logic                          err_misaligned
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t                        state_q, state_d;
    logic [XLEN-1:0]               addr_q;
    logic [15:0]                   remain_q;
    logic                          infl_q, infl_last_q;
    logic [XLEN-1:0]               infl_addr_q;
    logic [XLEN-1:0]               fa_q [2];
    logic [INSTRUCTION_LENGTH-1:0] fi_q [2];
    logic                          fl_q [2];
    logic                          wr_ptr_q, rd_ptr_q;
    logic [1:0]                    cnt_q;
    logic                          done_q, err_q;

    logic accept, misaligned, zero_cnt, push, pop, credit_ok, last_issue;

    assign accept     = req_valid && req_ready;
    assign misaligned = (req_start_addr[1:0] != 2'b00);
    assign zero_cnt   = (req_count == 16'd0);
    assign push       = infl_q;
    assign pop        = out_valid && out_ready;
    // Occupancy after this cycle's pop plus the read in flight must leave a free slot.
    assign credit_ok  = ({1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, pop}) < 3'd2;
    assign last_issue = mem_rd_en && (remain_q == 16'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && !misaligned && !zero_cnt) state_d = FETCH;
            FETCH:   if (last_issue)                         state_d = DRAIN;
            DRAIN:   if (pop && out_last)                    state_d = IDLE;
            default:                                         state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        busy      = (state_q != IDLE);
        mem_rd_en = (state_q == FETCH) && credit_ok;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q      <= '0;
            remain_q    <= '0;
            infl_q      <= 1'b0;
            infl_addr_q <= '0;
            infl_last_q <= 1'b0;
        end else begin
            infl_q <= mem_rd_en;
            if (accept && !misaligned && !zero_cnt) begin
                addr_q   <= req_start_addr;
                remain_q <= req_count;
            end else if (mem_rd_en) begin
                addr_q   <= addr_q + XLEN'(4);
                remain_q <= remain_q - 16'd1;
            end
            if (mem_rd_en) begin
                infl_addr_q <= addr_q;
                infl_last_q <= (remain_q == 16'd1);
            end
        end
    end

    // Read data is captured into the FIFO in the one cycle it is valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fa_q[0]  <= '0;
            fa_q[1]  <= '0;
            fi_q[0]  <= '0;
            fi_q[1]  <= '0;
            fl_q[0]  <= 1'b0;
            fl_q[1]  <= 1'b0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                fa_q[wr_ptr_q] <= infl_addr_q;
                fi_q[wr_ptr_q] <= mem_rd_data;
                fl_q[wr_ptr_q] <= infl_last_q;
                wr_ptr_q       <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= (accept && !misaligned && zero_cnt) || (pop && out_last);
            err_q  <= accept && misaligned;
        end
    end

    assign mem_rd_addr    = addr_q;
    assign out_valid      = (cnt_q != 2'd0);
    assign out_addr       = fa_q[rd_ptr_q];
    assign out_instr      = fi_q[rd_ptr_q];
    assign out_last       = fl_q[rd_ptr_q];
    assign done           = done_q;
    assign err_misaligned = err_q;
endmodule

// File: tb/tb_dbg_imem_reader.sv
// Directed bench for dbg_imem_reader: streaming, stalls, error/zero-count, wrap and mid-run reset.
module tb_dbg_imem_reader;
    localparam int XLEN = 64;
    localparam int IL   = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [XLEN-1:0] req_start_addr = '0;
    logic [15:0]     req_count = '0;
    logic            mem_rd_en;
    logic [XLEN-1:0] mem_rd_addr;
    logic [IL-1:0]   mem_rd_data = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [XLEN-1:0] out_addr;
    logic [IL-1:0]   out_instr;
    logic            out_last;
    logic            busy, done, err_misaligned;

    int n_assert = 0;
    int n_fail   = 0;
    int issued   = 0;
    int popped   = 0;
    bit mem_seen = 0;

    dbg_imem_reader #(.XLEN(XLEN), .INSTRUCTION_LENGTH(IL)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_start_addr(req_start_addr), .req_count(req_count),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_instr(out_instr), .out_last(out_last), .busy(busy), .done(done),
        .err_misaligned(err_misaligned)
    );

    always #5 clk = ~clk;

    // addi x1,x0,1 / slti x2,x0,2 / sltiu x3,x0,3 / andi x4,x0,4 at 0..12
    function automatic logic [IL-1:0] imem(input logic [XLEN-1:0] a);
        case (a)
            64'd0:   return 32'h0010_0093;
            64'd4:   return 32'h0020_2113;
            64'd8:   return 32'h0030_3193;
            64'd12:  return 32'h0040_7213;
            default: return a[31:0] ^ 32'h5A5A_5A5A;
        endcase
    endfunction

    always @(posedge clk) if (mem_rd_en) mem_rd_data <= imem(mem_rd_addr);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Credit monitor: reads outstanding (in flight or buffered) minus this cycle's pop stay below 2.
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            issued = 0;
            popped = 0;
        end else begin
            if (mem_rd_en) begin
                mem_seen = 1;
                chk("credit", 64'((issued - popped - int'(out_valid && out_ready)) < 2), 64'd1);
                issued++;
            end
            if (out_valid && out_ready) popped++;
        end
    end

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        chk({tag, "_mem_rd_en"}, 64'(mem_rd_en), 64'd0);
        chk({tag, "_mem_rd_addr"}, mem_rd_addr, 64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_addr"}, out_addr, 64'd0);
        chk({tag, "_out_instr"}, 64'(out_instr), 64'd0);
        chk({tag, "_out_last"}, 64'(out_last), 64'd0);
        chk({tag, "_busy_done_err"}, {61'd0, busy, done, err_misaligned}, 64'd0);
    endtask

    // Issue one request and check every output word, stall stability, first-word latency and done.
    task automatic run_req(input logic [XLEN-1:0] start, input int cnt, input bit toggle, input string tag);
        int i = 0, cyc = 1, first = -1, last_hs = -10;
        bit got_done = 0, pv = 0, pr = 1, pl = 0;
        logic [XLEN-1:0] pa = '0;
        logic [IL-1:0] pi = '0;
        @(negedge clk);
        req_valid = 1; req_start_addr = start; req_count = 16'(cnt); out_ready = 1;
        #1 chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 0;
        while (!got_done && cyc < 200) begin
            out_ready = toggle ? cyc[0] : 1'b1;
            #1;
            if (out_valid && first < 0) first = cyc;
            if (pv && !pr)
                chk({tag, "_stable"}, 64'({out_valid, out_addr, out_instr, out_last} == {1'b1, pa, pi, pl}), 64'd1);
            if (out_valid) begin
                chk({tag, "_addr"}, out_addr, start + XLEN'(4 * i));
                chk({tag, "_instr"}, 64'(out_instr), 64'(imem(start + XLEN'(4 * i))));
                chk({tag, "_last"}, 64'(out_last), 64'(i == cnt - 1));
                if (out_ready) begin
                    i++;
                    if (out_last) last_hs = cyc;
                end
            end
            if (done) begin
                got_done = 1;
                chk({tag, "_done_cycle"}, 64'(cyc), 64'(last_hs + 1));
                chk({tag, "_words"}, 64'(i), 64'(cnt));
                chk({tag, "_busy_end"}, 64'(busy), 64'd0);
            end
            pv = out_valid; pa = out_addr; pi = out_instr; pl = out_last; pr = out_ready;
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_finished"}, 64'(got_done), 64'd1);
        if (!toggle) chk({tag, "_first_latency"}, 64'(first), 64'd3);
        #1 chk({tag, "_done_pulse"}, 64'(done), 64'd0);
        out_ready = 1;
    endtask

    initial begin
        @(negedge clk);
        #1 chk_reset_outs("reset");
        @(negedge clk);
        rst = 1;
        #1 chk("release_req_ready", 64'(req_ready), 64'd1);

        run_req(64'd0, 4, 1'b0, "basic");
        run_req(64'd0, 4, 1'b1, "stall");

        @(negedge clk);
        mem_seen = 0; req_valid = 1; req_start_addr = 64'd6; req_count = 16'd2;
        @(negedge clk);
        req_valid = 0;
        #1 chk("mis_err", 64'(err_misaligned), 64'd1);
        chk("mis_busy", 64'(busy), 64'd0);
        @(negedge clk);
        #1 chk("mis_err_pulse", 64'(err_misaligned), 64'd0);
        chk("mis_busy2", 64'(busy), 64'd0);
        @(negedge clk);
        #3 chk("mis_no_reads", 64'(mem_seen), 64'd0);

        @(negedge clk);
        mem_seen = 0; req_valid = 1; req_start_addr = 64'd8; req_count = 16'd0;
        @(negedge clk);
        req_valid = 0;
        #1 chk("zero_done", 64'(done), 64'd1);
        chk("zero_valid", 64'(out_valid), 64'd0);
        chk("zero_busy", 64'(busy), 64'd0);
        @(negedge clk);
        #1 chk("zero_done_pulse", 64'(done), 64'd0);
        chk("zero_valid2", 64'(out_valid), 64'd0);
        #2 chk("zero_no_reads", 64'(mem_seen), 64'd0);

        run_req(64'hFFFF_FFFF_FFFF_FFF8, 4, 1'b0, "wrap");

        // Reset while the second word sits stalled at the output.
        @(negedge clk);
        req_valid = 1; req_start_addr = 64'h100; req_count = 16'd4; out_ready = 0;
        @(negedge clk);
        req_valid = 0;
        for (int k = 0; k < 10 && !out_valid; k++) begin
            @(negedge clk);
            #1;
        end
        chk("rst_first_valid", 64'(out_valid), 64'd1);
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        #1 chk("rst_second_addr", out_addr, 64'h104);
        @(negedge clk);
        rst = 0;
        #1 chk_reset_outs("midrst");
        @(negedge clk);
        #1 chk_reset_outs("midrst_hold");
        rst = 1;
        out_ready = 1;
        @(negedge clk);
        #1 chk("post_rst_valid", 64'(out_valid), 64'd0);
        run_req(64'h200, 3, 1'b0, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
